// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for hazard_ctrl: ID/EX hazard inputs, interrupt
// request, and the PC/IF/ID/ID-EX control outputs with FSM observability.
interface hazard_ctrl_if;
    logic       id_valid;
    logic [1:0] id_ra;
    logic [1:0] id_rb;
    logic       id_uses_ra;
    logic       id_uses_rb;
    logic       id_is_ret;
    logic       ex_mem_read;
    logic       ex_reg_write;
    logic [1:0] ex_rd;
    logic       ex_branch_taken;
    logic       intr_req;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_flush;
    logic       intr_ack;
    logic [2:0] hz_state;
    logic [7:0] stall_cnt;

    modport master (
        output id_valid, id_ra, id_rb, id_uses_ra, id_uses_rb, id_is_ret,
               ex_mem_read, ex_reg_write, ex_rd, ex_branch_taken, intr_req,
        input  pc_write, ifid_write, ifid_flush, idex_flush, intr_ack,
               hz_state, stall_cnt
    );

    modport slave (
        input  id_valid, id_ra, id_rb, id_uses_ra, id_uses_rb, id_is_ret,
               ex_mem_read, ex_reg_write, ex_rd, ex_branch_taken, intr_req,
        output pc_write, ifid_write, ifid_flush, idex_flush, intr_ack,
               hz_state, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, RET bubble sequence
// and (with HAZ_INTR_EN defined) edge-triggered interrupt entry sequence.
module hazard_ctrl (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hif
);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        RET_W1 = 3'd1,
        RET_W2 = 3'd2,
        INT_W1 = 3'd3,
        INT_W2 = 3'd4
    } hz_state_e;

    hz_state_e  state, state_nx;
    logic       load_use;
    logic       pend;
    logic       take_intr;
    logic       pcw_c, ifw_c, iff_c, idf_c;
    logic [7:0] cnt;

    assign load_use = hif.ex_mem_read & hif.ex_reg_write & hif.id_valid &
                      ((hif.id_uses_ra & (hif.id_ra == hif.ex_rd)) |
                       (hif.id_uses_rb & (hif.id_rb == hif.ex_rd)));

`ifdef HAZ_INTR_EN
    logic intr_q;
    logic intr_edge;

    assign intr_edge = hif.intr_req & ~intr_q;

    // A new edge in the same cycle as acceptance keeps the request pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            intr_q <= 1'b0;
            pend   <= 1'b0;
        end else begin
            intr_q <= hif.intr_req;
            pend   <= intr_edge | (pend & ~take_intr);
        end
    end

    assign hif.intr_ack = take_intr & ~rst;
`else
    logic unused_intr;

    assign pend        = 1'b0;
    assign unused_intr = &{1'b0, hif.intr_req, take_intr};
    assign hif.intr_ack = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = RUN;
        pcw_c     = 1'b1;
        ifw_c     = 1'b1;
        iff_c     = 1'b0;
        idf_c     = 1'b0;
        take_intr = 1'b0;
        if (hif.ex_branch_taken) begin
            iff_c = 1'b1;
            idf_c = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (load_use) begin
                        pcw_c = 1'b0;
                        ifw_c = 1'b0;
                        idf_c = 1'b1;
                    end else if (hif.id_valid && hif.id_is_ret) begin
                        pcw_c    = 1'b0;
                        iff_c    = 1'b1;
                        state_nx = RET_W1;
                    end else if (pend) begin
                        take_intr = 1'b1;
                        pcw_c     = 1'b0;
                        iff_c     = 1'b1;
                        state_nx  = INT_W1;
                    end
                end
                RET_W1: begin
                    pcw_c    = 1'b0;
                    iff_c    = 1'b1;
                    state_nx = RET_W2;
                end
                RET_W2: iff_c = 1'b1;
`ifdef HAZ_INTR_EN
                INT_W1: begin
                    pcw_c    = 1'b0;
                    iff_c    = 1'b1;
                    state_nx = INT_W2;
                end
                INT_W2: iff_c = 1'b1;
`endif
                default: state_nx = RUN;
            endcase
        end
    end

    assign hif.pc_write   = pcw_c & ~rst;
    assign hif.ifid_write = ifw_c & ~rst;
    assign hif.ifid_flush = iff_c & ~rst;
    assign hif.idex_flush = idf_c & ~rst;
    assign hif.hz_state   = state;
    assign hif.stall_cnt  = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        cnt <= 8'd0;
        else if (!pcw_c && cnt != 8'hFF) cnt <= cnt + 8'd1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized run
// against a sequence-level reference model.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    hazard_ctrl_if hif ();

    hazard_ctrl dut (.clk(clk), .rst(rst), .hif(hif));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {pc_write, ifid_write, ifid_flush, idex_flush, intr_ack}
    function automatic logic [4:0] outs();
        return {hif.pc_write, hif.ifid_write, hif.ifid_flush, hif.idex_flush, hif.intr_ack};
    endfunction

    task automatic idle();
        hif.id_valid = 0; hif.id_ra = 0; hif.id_rb = 0;
        hif.id_uses_ra = 0; hif.id_uses_rb = 0; hif.id_is_ret = 0;
        hif.ex_mem_read = 0; hif.ex_reg_write = 0; hif.ex_rd = 0;
        hif.ex_branch_taken = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; idle(); hif.intr_req = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic set_lu();
        hif.ex_mem_read = 1; hif.ex_reg_write = 1; hif.ex_rd = 2;
        hif.id_valid = 1; hif.id_ra = 2; hif.id_uses_ra = 1;
    endtask

    initial begin
        // reference-model state: remaining sequence cycles and its kind
        int   seq_left;
        bit   seq_int;
        bit   pend, prev;
        int   cnt;
        bit   br, lu, ret, take, edge_s;
        logic [4:0] e_out;
        logic [2:0] e_hz;

        idle(); hif.intr_req = 0;
        @(negedge clk); #1;
        chk("rst_outs", outs(), 5'b00000);
        chk("rst_cnt", hif.stall_cnt, 0);
        chk("rst_state", hif.hz_state, 0);
        @(negedge clk); rst = 0; #1;
        chk("idle_outs", outs(), 5'b11000);

        // load-use: one bubble
        @(negedge clk); set_lu(); #1;
        chk("lu_stall", outs(), 5'b00010);
        @(negedge clk); hif.ex_mem_read = 0; #1;
        chk("lu_clear", outs(), 5'b11000);
        chk("lu_cnt", hif.stall_cnt, 1);

        // no hazard when the matching source is unused
        @(negedge clk); set_lu(); hif.id_uses_ra = 0; hif.id_uses_rb = 1; hif.id_rb = 1; #1;
        chk("lu_none", outs(), 5'b11000);
        @(negedge clk); idle(); #1;
        chk("lu_none_cnt", hif.stall_cnt, 1);

        // RET sequence
        do_reset();
        hif.id_valid = 1; hif.id_is_ret = 1; #1;
        chk("ret0_hz", hif.hz_state, 0);
        chk("ret0_out", outs(), 5'b01100);
        @(negedge clk); idle(); #1;
        chk("ret1_hz", hif.hz_state, 1);
        chk("ret1_out", outs(), 5'b01100);
        @(negedge clk); #1;
        chk("ret2_hz", hif.hz_state, 2);
        chk("ret2_out", outs(), 5'b11100);
        @(negedge clk); #1;
        chk("ret3_hz", hif.hz_state, 0);
        chk("ret3_out", outs(), 5'b11000);
        chk("ret_cnt", hif.stall_cnt, 2);

        // branch aborts RET_W1
        @(negedge clk); hif.id_valid = 1; hif.id_is_ret = 1;
        @(negedge clk); idle(); hif.ex_branch_taken = 1; #1;
        chk("brret_hz", hif.hz_state, 1);
        chk("brret_out", outs(), 5'b11110);
        @(negedge clk); idle(); #1;
        chk("brret_next", hif.hz_state, 0);
        chk("brret_idle", outs(), 5'b11000);

`ifdef HAZ_INTR_EN
        // interrupt edge during a load-use stall is deferred
        do_reset();
        set_lu(); hif.intr_req = 1; #1;
        chk("int_lu", outs(), 5'b00010);
        @(negedge clk); idle(); #1;
        chk("int_ack", outs(), 5'b01101);
        chk("int_ack_hz", hif.hz_state, 0);
        @(negedge clk); #1;
        chk("int_w1_hz", hif.hz_state, 3);
        chk("int_w1_out", outs(), 5'b01100);
        @(negedge clk); #1;
        chk("int_w2_hz", hif.hz_state, 4);
        chk("int_w2_out", outs(), 5'b11100);
        @(negedge clk); #1;
        chk("int_end_hz", hif.hz_state, 0);
        chk("int_end_out", outs(), 5'b11000);

        // reset while in INT_W1
        @(negedge clk); hif.intr_req = 0;
        @(negedge clk); hif.intr_req = 1; #1;
        chk("int2_pre", outs(), 5'b11000);
        @(negedge clk); #1;
        chk("int2_ack", outs(), 5'b01101);
        @(negedge clk); #1;
        chk("int2_w1", hif.hz_state, 3);
        rst = 1; hif.intr_req = 0; #1;
`else
        // interrupt request is ignored
        @(negedge clk); hif.intr_req = 1;
        @(negedge clk); #1;
        chk("noint_out", outs(), 5'b11000);
        @(negedge clk); hif.intr_req = 0; #1;
        chk("noint_hz", hif.hz_state, 0);

        // reset while in RET_W1
        @(negedge clk); hif.id_valid = 1; hif.id_is_ret = 1;
        @(negedge clk); idle(); #1;
        chk("rret_w1", hif.hz_state, 1);
        rst = 1; #1;
`endif
        chk("mid_rst_out", outs(), 5'b00000);
        chk("mid_rst_cnt", hif.stall_cnt, 0);
        chk("mid_rst_hz", hif.hz_state, 0);
        @(negedge clk); rst = 0; #1;
        chk("post_rst_out", outs(), 5'b11000);

        // stall counter saturates
        do_reset();
        set_lu();
        repeat (260) @(negedge clk);
        #1;
        chk("sat_cnt", hif.stall_cnt, 255);
        chk("sat_out", outs(), 5'b00010);

        // randomized run against the reference model
        do_reset();
        seq_left = 0; seq_int = 0; pend = 0; prev = 0; cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i != 0) @(negedge clk);
            hif.id_valid        = $urandom_range(0, 3) != 0;
            hif.id_ra           = 2'($urandom_range(0, 3));
            hif.id_rb           = 2'($urandom_range(0, 3));
            hif.id_uses_ra      = $urandom_range(0, 1) == 1;
            hif.id_uses_rb      = $urandom_range(0, 1) == 1;
            hif.id_is_ret       = $urandom_range(0, 7) == 0;
            hif.ex_mem_read     = $urandom_range(0, 2) == 0;
            hif.ex_reg_write    = $urandom_range(0, 3) != 0;
            hif.ex_rd           = 2'($urandom_range(0, 3));
            hif.ex_branch_taken = $urandom_range(0, 9) == 0;
            if ($urandom_range(0, 5) == 0) hif.intr_req = ~hif.intr_req;
            #1;

            br  = hif.ex_branch_taken;
            lu  = hif.ex_mem_read && hif.ex_reg_write && hif.id_valid &&
                  ((hif.id_uses_ra && hif.id_ra == hif.ex_rd) ||
                   (hif.id_uses_rb && hif.id_rb == hif.ex_rd));
            ret = hif.id_valid && hif.id_is_ret;
            take = 0;
            if (seq_left == 0)      e_hz = 0;
            else if (seq_int)       e_hz = (seq_left == 2) ? 3'd3 : 3'd4;
            else                    e_hz = (seq_left == 2) ? 3'd1 : 3'd2;

            if (br) begin
                e_out = 5'b11110; seq_left = 0;
            end else if (seq_left > 0) begin
                e_out = (seq_left == 1) ? 5'b11100 : 5'b01100;
                seq_left--;
            end else if (lu) begin
                e_out = 5'b00010;
            end else if (ret) begin
                e_out = 5'b01100; seq_left = 2; seq_int = 0;
            end else if (pend) begin
                e_out = 5'b01101; seq_left = 2; seq_int = 1; take = 1;
            end else begin
                e_out = 5'b11000;
            end

            chk("rnd_out", outs(), e_out);
            chk("rnd_hz", hif.hz_state, e_hz);
            chk("rnd_cnt", hif.stall_cnt, cnt);

            if (!e_out[4] && cnt < 255) cnt++;
`ifdef HAZ_INTR_EN
            edge_s = hif.intr_req && !prev;
            pend   = edge_s || (pend && !take);
            prev   = hif.intr_req;
`else
            edge_s = 0;
`endif
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port id_valid, input, 1 bit: the ID stage holds a valid instruction.
REQ-004 The block SHALL have the ports id_ra and id_rb, input, 2 bits each: the ID-stage source register addresses.
REQ-005 The block SHALL have the ports id_uses_ra and id_uses_rb, input, 1 bit each: the ID instruction reads that source.
REQ-006 The block SHALL have the port id_is_ret, input, 1 bit: the ID instruction is RET or RTI.
REQ-007 The block SHALL have the ports ex_mem_read and ex_reg_write, input, 1 bit each: the MemRead and RegWrite outputs of the ID/EX register.
REQ-008 The block SHALL have the port ex_rd, input, 2 bits: the destination register of the EX-stage instruction.
REQ-009 The block SHALL have the port ex_branch_taken, input, 1 bit: a taken branch or call has resolved in EX.
REQ-010 The block SHALL have the port intr_req, input, 1 bit: external interrupt request; its rising edge is significant.
REQ-011 The block SHALL have the ports pc_write and ifid_write, output, 1 bit each: the PC and IF/ID load enables.
REQ-012 The block SHALL have the ports ifid_flush and idex_flush, output, 1 bit each: idex_flush drives the flush input of the ID/EX register.
REQ-013 The block SHALL have the port intr_ack, output, 1 bit: a one-cycle interrupt acceptance pulse.
REQ-014 The block SHALL have the ports hz_state (output, 3 bits, FSM state) and stall_cnt (output, 8 bits, count of stall cycles).

Function
REQ-015 The FSM states SHALL be encoded RUN=0, RET_W1=1, RET_W2=2, INT_W1=3, INT_W2=4; codes 5-7 SHALL return to RUN on the next clock.
REQ-016 Outputs SHALL be Mealy (combinational from state plus inputs); the default in RUN with no hazard is pc_write=1, ifid_write=1, flushes=0, intr_ack=0.
REQ-017 When ex_branch_taken=1 in any state, the block SHALL assert ifid_flush=1 and idex_flush=1 with pc_write=1, and the next state SHALL be RUN; this condition has the highest priority.
REQ-018 A load-use hazard SHALL be defined as ex_mem_read & ex_reg_write & id_valid & ((id_uses_ra & id_ra==ex_rd) | (id_uses_rb & id_rb==ex_rd)).
REQ-019 A load-use hazard in RUN (without a branch) SHALL produce pc_write=0, ifid_write=0 and idex_flush=1, giving exactly a one-bubble stall; the state SHALL remain RUN.
REQ-020 id_valid & id_is_ret in RUN (without a branch or load-use hazard) SHALL let the RET advance into EX, assert pc_write=0 and ifid_flush=1, and move the FSM to RET_W1.
REQ-021 RET_W1 SHALL assert pc_write=0 and ifid_flush=1, then move to RET_W2.
REQ-022 RET_W2 SHALL assert pc_write=1 (the datapath loads the popped address) and ifid_flush=1, then move to RUN; a RET therefore costs 3 fetch bubbles.
REQ-023 A rising edge of intr_req SHALL set a pending flag.
REQ-024 The interrupt SHALL be taken only in RUN with no branch, load-use or RET condition; the block SHALL then pulse intr_ack=1 and assert ifid_flush=1 and pc_write=0, and move to INT_W1.
REQ-025 Taking the interrupt SHALL clear the pending flag; if a new edge arrives in the same cycle, set wins.
REQ-026 INT_W1 SHALL assert pc_write=0 and ifid_flush=1, then move to INT_W2.
REQ-027 INT_W2 SHALL assert pc_write=1 (the datapath loads the vector) and ifid_flush=1, then move to RUN.
REQ-028 A pending interrupt SHALL be deferred, not lost, across stalls, RET sequences and branch aborts.
REQ-029 stall_cnt SHALL increment on every clock where pc_write=0 and SHALL saturate at 255 (no wrap).

Reset
REQ-030 While rst=1, the block SHALL set state=RUN, pending=0, the edge-detect register=0 and stall_cnt=0.
REQ-031 While rst=1, the outputs SHALL be forced to pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=0 and intr_ack=0.
REQ-032 Reset asserted mid-sequence (RET_W*/INT_W*) SHALL abandon the sequence immediately, and the first cycle after release SHALL be RUN.

Configuration
REQ-033 With HAZ_INTR_EN defined, the interrupt logic of REQ-023 to REQ-028 SHALL be present.
REQ-034 With HAZ_INTR_EN undefined, intr_req SHALL be ignored, intr_ack SHALL be tied to 0, the pending flag SHALL be absent, and states 3 and 4 SHALL be treated as illegal codes that return to RUN.

Verification
REQ-035 The bench SHALL check load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=2, id_ra=2, id_uses_ra=1 -> exactly one cycle of pc_write=0, ifid_write=0, idex_flush=1, and stall_cnt=1.
REQ-036 The bench SHALL check that with the same ex_rd=2, id_uses_ra=0 and id_rb=1 -> no stall.
REQ-037 The bench SHALL check RET: id_is_ret=1 in RUN -> hz_state sequence 0,1,2,0; pc_write 0,0,1; ifid_flush=1 for 3 cycles; stall_cnt=2.
REQ-038 The bench SHALL check that ex_branch_taken=1 while in RET_W1 -> both flushes=1 and the next state is RUN.
REQ-039 The bench SHALL check that an intr_req edge during a load-use stall -> intr_ack pulses one cycle after the stall clears, followed by hz_state 3, 4, 0.
REQ-040 The bench SHALL check that rst=1 asserted while in INT_W1 -> all outputs 0 and stall_cnt=0, and pc_write=1 in the first clock after release.
